// File: rtl/timer_prog_multi.sv
// Multi-channel programmable interval timer sharing one run-time prescaler.
// Define TIMER_PROG_IRQ_EN to add sticky per-channel irq flags with irq_clear.
module timer_prog_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
`ifdef TIMER_PROG_IRQ_EN
    ,
    input  logic [CHANNELS-1:0]       irq_clear,
    output logic [CHANNELS-1:0]       irq
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    logic [PRESCALE_W-1:0] pre_reg;
    logic [PRESCALE_W-1:0] pre_next;
    logic                  tick;

    // The >= compare lets a lowered prescale take effect immediately.
    always_comb begin
        tick     = enable && (pre_reg >= prescale);
        pre_next = pre_reg;
        if (enable) begin
            pre_next = tick ? '0 : pre_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            state_t           state_reg, state_next;
            logic [WIDTH-1:0] count_reg, count_next;
            logic [WIDTH-1:0] final_reg, final_next;
            logic             mode_reg, mode_next;
            logic             done_reg, done_next;

            // Priority: stop > start > tick; a restart swallows a coinciding terminal tick.
            always_comb begin
                state_next = state_reg;
                count_next = count_reg;
                final_next = final_reg;
                mode_next  = mode_reg;
                done_next  = 1'b0;
                if (stop[gi]) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (start[gi]) begin
                    state_next = RUN;
                    count_next = '0;
                    final_next = load_value[gi*WIDTH +: WIDTH];
                    mode_next  = periodic[gi];
                end else if (state_reg == RUN && tick) begin
                    if (count_reg == final_reg) begin
                        done_next = 1'b1;
                        if (mode_reg) begin
                            count_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    final_reg <= '0;
                    mode_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                    final_reg <= final_next;
                    mode_reg  <= mode_next;
                    done_reg  <= done_next;
                end
            end

            assign count[gi*WIDTH +: WIDTH] = count_reg;
            assign busy[gi]                 = (state_reg == RUN);
            assign done[gi]                 = done_reg;

`ifdef TIMER_PROG_IRQ_EN
            logic irq_reg;

            // Set wins over a clear landing in the same cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    irq_reg <= 1'b0;
                end else if (done_reg) begin
                    irq_reg <= 1'b1;
                end else if (irq_clear[gi]) begin
                    irq_reg <= 1'b0;
                end
            end

            assign irq[gi] = irq_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_timer_prog_multi.sv
// Directed bench for timer_prog_multi with four 8-bit channels.
// Expected counts and cycle spacings are hand-derived from the timer behaviour.
module tb_timer_prog_multi;
    localparam int W = 8;
    localparam int C = 4;
    localparam int P = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [P-1:0]   prescale;
    logic [C-1:0]   start, stop, periodic;
    logic [C*W-1:0] load_value;
    logic [C*W-1:0] count;
    logic [C-1:0]   busy, done;
`ifdef TIMER_PROG_IRQ_EN
    logic [C-1:0]   irq_clear, irq;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    timer_prog_multi #(.WIDTH(W), .CHANNELS(C), .PRESCALE_W(P)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .prescale(prescale),
        .start(start),
        .stop(stop),
        .periodic(periodic),
        .load_value(load_value),
        .count(count),
        .busy(busy),
        .done(done)
`ifdef TIMER_PROG_IRQ_EN
        ,
        .irq_clear(irq_clear),
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Outputs are observed 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [W-1:0] cnt(input int ch);
        return count[ch*W +: W];
    endfunction

    task automatic set_load(input int ch, input logic [W-1:0] v);
        load_value[ch*W +: W] = v;
    endtask

    task automatic pulse_start(input logic [C-1:0] mask, input logic [C-1:0] pmask);
        start    = mask;
        periodic = pmask;
        step();
        start    = '0;
    endtask

    task automatic stop_all();
        stop = '1;
        step();
        stop = '0;
    endtask

    task automatic wait_done(input int ch, input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (done[ch]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int t0, t1, ts, c;
        int first[C];
        int second[C];

        reset = 1'b1; enable = 1'b0; prescale = '0;
        start = '0; stop = '0; periodic = '0; load_value = '0;
`ifdef TIMER_PROG_IRQ_EN
        irq_clear = '0;
`endif
        repeat (3) step();
        check("reset_count", count, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;

        // One-shot, final 5, tick every cycle.
        enable = 1'b1; prescale = 0;
        set_load(0, 5);
        pulse_start(4'b0001, 4'b0000);
        check("os_busy_rise", busy[0], 1);
        for (int k = 0; k <= 5; k++) begin
            check("os_count", cnt(0), k);
            check("os_no_done", done[0], 0);
            step();
        end
        check("os_done", done[0], 1);
        check("os_busy_fall", busy[0], 0);
        check("os_count_hold", cnt(0), 5);
        step();
        check("os_done_width", done[0], 0);
        check("os_count_hold2", cnt(0), 5);

        // Periodic ch1, final 2, prescale 3: period 12.
        prescale = 3;
        set_load(1, 2);
        pulse_start(4'b0010, 4'b0010);
        wait_done(1, 20, t0);
        check("per_count_wrap", cnt(1), 0);
        repeat (4) step();
        check("per_count1", cnt(1), 1);
        repeat (4) step();
        check("per_count2", cnt(1), 2);
        repeat (4) step();
        check("per_done_12", done[1], 1);
        t0 = cyc;
        for (int p = 0; p < 3; p++) begin
            wait_done(1, 20, t1);
            check("per_spacing", t1 - t0, 12);
            t0 = t1;
        end
        stop_all();
        check("stop_busy", busy, 0);
        check("stop_count", cnt(1), 0);

        // Enable gating stretches a period of 8 by exactly 10 cycles.
        prescale = 1;
        set_load(2, 3);
        pulse_start(4'b0100, 4'b0100);
        wait_done(2, 20, t0);
        repeat (3) step();
        c = cnt(2);
        enable = 1'b0;
        repeat (10) step();
        check("gate_count_frozen", cnt(2), c);
        enable = 1'b1;
        wait_done(2, 30, t1);
        check("gate_spacing", t1 - t0, 18);
        stop_all();

        // stop and start together: stop wins.
        prescale = 0;
        set_load(0, 5);
        pulse_start(4'b0001, 4'b0000);
        repeat (2) step();
        start = 4'b0001; stop = 4'b0001;
        step();
        start = '0; stop = '0;
        check("ss_busy", busy[0], 0);
        check("ss_count", cnt(0), 0);
        check("ss_done", done[0], 0);

        // Restart on the terminal tick suppresses done.
        set_load(0, 2);
        pulse_start(4'b0001, 4'b0000);
        repeat (2) step();
        check("rs_count_at_final", cnt(0), 2);
        pulse_start(4'b0001, 4'b0000);
        ts = cyc;
        check("rs_no_done", done[0], 0);
        check("rs_busy", busy[0], 1);
        check("rs_count", cnt(0), 0);
        wait_done(0, 6, t1);
        check("rs_latency", t1 - ts, 3);

        // Reset mid-run clears everything on the next cycle.
        set_load(0, 10); set_load(1, 7);
        pulse_start(4'b0011, 4'b0010);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_count", count, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);

        // Final value 0: done on every tick.
        prescale = 0;
        set_load(3, 0);
        pulse_start(4'b1000, 4'b1000);
        for (int k = 0; k < 4; k++) begin
            step();
            check("zero_done_every", done[3], 1);
        end
        prescale = 2;
        wait_done(3, 6, t0);
        wait_done(3, 6, t1);
        check("zero_spacing_p2", t1 - t0, 3);
        stop_all();

        // Final value 255: 256 ticks, no overflow.
        prescale = 0;
        set_load(0, 255);
        pulse_start(4'b0001, 4'b0000);
        ts = cyc;
        wait_done(0, 300, t1);
        check("max_latency", t1 - ts, 256);
        check("max_count", cnt(0), 255);
        check("max_busy", busy[0], 0);

        // Four channels concurrently, prescale 1: periods 4, 6, 8, 10.
        prescale = 1;
        for (int ch = 0; ch < C; ch++) begin
            set_load(ch, W'(ch + 1));
            first[ch] = -1;
            second[ch] = -1;
        end
        pulse_start(4'b1111, 4'b1111);
        ts = cyc;
        for (int k = 0; k < 40; k++) begin
            step();
            for (int ch = 0; ch < C; ch++) begin
                if (done[ch]) begin
                    if (first[ch] < 0) first[ch] = cyc;
                    else if (second[ch] < 0) second[ch] = cyc;
                end
            end
        end
        for (int ch = 0; ch < C; ch++) begin
            check("multi_period", second[ch] - first[ch], (ch + 2) * 2);
            check("multi_first_ok", (first[ch] > ts) && (first[ch] - ts <= (ch + 2) * 2), 1);
        end
        stop_all();

`ifdef TIMER_PROG_IRQ_EN
        prescale = 0;
        set_load(0, 1);
        pulse_start(4'b0001, 4'b0000);
        wait_done(0, 5, t1);
        check("irq_not_yet", irq[0], 0);
        step();
        check("irq_set", irq[0], 1);
        step();
        check("irq_sticky", irq[0], 1);
        irq_clear = 4'b0001;
        step();
        irq_clear = '0;
        check("irq_cleared", irq[0], 0);
        set_load(0, 0);
        pulse_start(4'b0001, 4'b0001);
        repeat (3) step();
        irq_clear = 4'b0001;
        step();
        irq_clear = '0;
        check("irq_set_wins", irq[0], 1);
        stop_all();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timer_prog_multi.md
# timer_prog_multi

Parametrised, multi-channel programmable interval timer. Generalises the fixed-final-value timer: width, channel count and final value are configurable, each channel runs one-shot or periodic, and all channels share a run-time prescaler. It sits beside the control FSMs and supplies them with timeouts and periodic ticks.

## Interface

Parameters:
- `WIDTH`, 8: width of each channel's counter and load value.
- `CHANNELS`, 2: number of independent timer channels (≥1).
- `PRESCALE_W`, 8: width of the prescaler divide value.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: global count enable; gates the prescaler.
- `prescale` in `PRESCALE_W`: a tick occurs every `prescale+1` enabled cycles.
- `start` in `CHANNELS`: per-channel start/restart strobe.
- `stop` in `CHANNELS`: per-channel abort strobe.
- `periodic` in `CHANNELS`: mode, sampled at start (1 = periodic, 0 = one-shot).
- `load_value` in `CHANNELS*WIDTH`: final value for each channel; channel i uses bits `[i*WIDTH +: WIDTH]`; sampled at start.
- `count` out `CHANNELS*WIDTH`: current count per channel, same packing.
- `busy` out `CHANNELS`: channel is in RUN.
- `done` out `CHANNELS`: one-cycle pulse when the channel reaches its final value.

## Operation

- **Prescaler:** `pre_reg` is `PRESCALE_W` bits.
  - While `enable`=1: `tick`=(`pre_reg` ≥ `prescale`). On `tick`, `pre_reg`←0; otherwise `pre_reg`←`pre_reg`+1.
  - While `enable`=0: `pre_reg` holds and `tick`=0.
  - The ≥ compare makes a lowered `prescale` take effect without a long wrap.
  - `prescale`=0 gives a tick on every enabled cycle.
- **Per-channel FSM**, states IDLE and RUN. Each channel latches `final_i` and `mode_i`.
  - **IDLE:** `count` holds its value. On `start`: `final_i`←`load_value`, `mode_i`←`periodic`, `count`←0, go to RUN.
  - **RUN, tick with `count`≠`final_i`:** `count`←`count`+1.
  - **RUN, tick with `count`=`final_i`:** assert `done` on the next cycle.
    - Periodic: `count`←0 and stay in RUN.
    - One-shot: go to IDLE with `count` holding `final_i`.
  - **RUN, no tick:** hold.
- **Priority per channel:** `reset` > `stop` > `start` > tick.
  - `stop` (IDLE or RUN): go to IDLE, `count`←0, no `done`.
  - `start` while in RUN restarts the channel (relatch, `count`←0). No `done` is produced in that cycle even if a terminal tick coincides.
- **Boundary conditions:**
  - `final_i`=0 gives `done` on every tick.
  - `final_i`=2^WIDTH−1 is legal. `count` never overflows because it resets at `final_i`.
  - Channels are fully independent apart from the shared `tick`.
  - `start`/`stop` act even while `enable`=0.
  - `load_value`/`periodic` changes while in RUN have no effect until the next `start`.

## Timing

- **Reset values:** `pre_reg`=0, every channel IDLE, `count`=0, `busy`=0, `done`=0, `final_i`=0, `mode_i`=0 (and `irq`=0 when the configured feature is compiled in).
- **Registered outputs:** `count`, `busy` and `done` are all registered.
  - `busy` rises the cycle after `start` is sampled.
  - `busy` falls in the same cycle `done` is high (one-shot), or the cycle after `stop`.
- **Period:** with `enable` held high, the `done` pulses of a periodic channel are spaced exactly (`final`+1)·(`prescale`+1) cycles apart.
- **First `done` latency after `start` (one-shot or periodic):** ≤ (`final`+1)·(`prescale`+1) cycles. The prescaler is free-running, so the first tick phase is not aligned to `start`.
- **`done` width:** exactly one cycle; never asserted two consecutive cycles unless `final`=0 and `prescale`=0.
- **Reset mid-count:** clears all state in the next cycle; no `done` is emitted.

## Configuration

- **`TIMER_PROG_IRQ_EN` defined:**
  - Adds input `irq_clear` [`CHANNELS`] and output `irq` [`CHANNELS`].
  - `irq_i` sets on `done_i` and holds until `irq_clear_i`.
  - If set and clear land in the same cycle, set wins.
  - `irq` resets to 0.
- **Not defined:** those ports and registers do not exist; `done` is the only completion indication.

## Test plan

- **One-shot:** `prescale`=0, `enable`=1, ch0 one-shot, `load_value`=5, `start` pulse → `count` steps 0..5, a single `done` on the cycle after `count`=5, `busy` falls with it, `count` holds 5.
- **Periodic with prescaler:** `prescale`=3, ch1 periodic, `load_value`=2 → `done` every 12 cycles for at least 4 periods; `count` cycles 0,1,2.
- **Enable gating:** deassert `enable` for 10 cycles mid-count → `count` and `pre_reg` frozen; the period stretches by exactly 10 cycles.
- **Start/stop priority:** `stop`+`start` in the same cycle → IDLE with `count`=0. `start` coinciding with a terminal tick → restart, no `done`. `reset` mid-run → all outputs 0 on the next cycle.
- **Edge values:** `load_value`=0 → `done` on every tick. `load_value`=255 with `WIDTH`=8 → `done` after 256 ticks, no overflow. `CHANNELS`=4 run concurrently with differing values → each `done` period is correct.
- **IRQ (`TIMER_PROG_IRQ_EN`):** `done` sets `irq`. `irq_clear` clears it one cycle later. `irq_clear` coinciding with `done` leaves `irq`=1.
